// File: rtl/reg_read_file_pkg.sv
// Shared selector codes and register index constants for the register read file.
// The write-back selector uses the same constants, so encode and decode stay consistent.
package reg_read_file_pkg;

    typedef enum logic [7:0] {
        SEL_RX    = 8'h05,
        SEL_RY    = 8'h06,
        SEL_RZ    = 8'h07,
        SEL_IN    = 8'h08,
        SEL_SP    = 8'h09,
        SEL_T     = 8'h0A,
        SEL_EMPTY = 8'h0B,
        SEL_R5    = 8'h29
    } src_sel_e;

    localparam logic [3:0] IDX_R5    = 4'h5;
    localparam logic [3:0] IDX_IN    = 4'h9;
    localparam logic [3:0] IDX_SP    = 4'hA;
    localparam logic [3:0] IDX_T     = 4'hB;
    localparam logic [3:0] IDX_EMPTY = 4'hF;

    localparam int NUM_REGS = 16;

    // The null register is never written and always reads zero.
    function automatic logic idx_is_null(input logic [3:0] idx);
        return idx == IDX_EMPTY;
    endfunction

endpackage

// File: rtl/reg_read_file_if.sv
// Write-back, read-select and ID/EX operand signals of the register read file.
interface reg_read_file_if #(
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        rd_sel_a;
    logic [7:0]        rd_sel_b;
    logic [3:0]        regx;
    logic [3:0]        regy;
    logic [3:0]        regz;
    logic              stall;
    logic              flush;
    logic [3:0]        idx_a;
    logic [3:0]        idx_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;

    modport master (
        output wr_en, wr_idx, wr_data, rd_sel_a, rd_sel_b,
               regx, regy, regz, stall, flush,
        input  idx_a, idx_b, data_a, data_b
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, rd_sel_a, rd_sel_b,
               regx, regy, regz, stall, flush,
        output idx_a, idx_b, data_a, data_b
    );
endinterface

// File: rtl/reg_src_decode.sv
// Combinational read-source selector decode: maps an 8-bit source code to a register index.
module reg_src_decode
    import reg_read_file_pkg::*;
(
    input  logic [7:0] sel,
    input  logic [3:0] regx,
    input  logic [3:0] regy,
    input  logic [3:0] regz,
    output logic [3:0] idx
);

    always_comb begin
        idx = IDX_EMPTY;
        case (sel)
            SEL_RX:    idx = regx;
            SEL_RY:    idx = regy;
            SEL_RZ:    idx = regz;
            SEL_IN:    idx = IDX_IN;
            SEL_SP:    idx = IDX_SP;
            SEL_T:     idx = IDX_T;
            SEL_R5:    idx = IDX_R5;
            SEL_EMPTY: idx = IDX_EMPTY;
            default:   idx = IDX_EMPTY;
        endcase
    end

endmodule

// File: rtl/reg_read_file.sv
// 16-entry register file with two bypassed read ports feeding the ID/EX operand register.
// Stall holds the operands but refreshes them from a matching write-back.
module reg_read_file
    import reg_read_file_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    reg_read_file_if.slave  bus
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    logic [3:0]        dec_idx_a;
    logic [3:0]        dec_idx_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [3:0]        idx_a_q, idx_a_d;
    logic [3:0]        idx_b_q, idx_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;

    function automatic logic wb_hit(input logic wr_en, input logic [3:0] wr_idx,
                                    input logic [3:0] idx);
        return wr_en && (wr_idx == idx) && !idx_is_null(idx);
    endfunction

    reg_src_decode u_dec_a (
        .sel  (bus.rd_sel_a),
        .regx (bus.regx),
        .regy (bus.regy),
        .regz (bus.regz),
        .idx  (dec_idx_a)
    );

    reg_src_decode u_dec_b (
        .sel  (bus.rd_sel_b),
        .regx (bus.regx),
        .regy (bus.regy),
        .regz (bus.regz),
        .idx  (dec_idx_b)
    );

    always_comb begin
        mem_d = mem_q;
        if (bus.wr_en && !idx_is_null(bus.wr_idx)) begin
            mem_d[bus.wr_idx] = bus.wr_data;
        end
    end

    // Same-cycle write-back wins over the stored value on either port.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (wb_hit(bus.wr_en, bus.wr_idx, dec_idx_a)) begin
            rd_a = bus.wr_data;
        end else if (!idx_is_null(dec_idx_a)) begin
            rd_a = mem_q[dec_idx_a];
        end
        if (wb_hit(bus.wr_en, bus.wr_idx, dec_idx_b)) begin
            rd_b = bus.wr_data;
        end else if (!idx_is_null(dec_idx_b)) begin
            rd_b = mem_q[dec_idx_b];
        end
    end

    always_comb begin
        idx_a_d  = idx_a_q;
        idx_b_d  = idx_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (bus.flush) begin
            idx_a_d  = IDX_EMPTY;
            idx_b_d  = IDX_EMPTY;
            data_a_d = '0;
            data_b_d = '0;
        end else if (bus.stall) begin
            // Held operands track writes to their register so a long stall never goes stale.
            if (wb_hit(bus.wr_en, bus.wr_idx, idx_a_q)) begin
                data_a_d = bus.wr_data;
            end
            if (wb_hit(bus.wr_en, bus.wr_idx, idx_b_q)) begin
                data_b_d = bus.wr_data;
            end
        end else begin
            idx_a_d  = dec_idx_a;
            idx_b_d  = dec_idx_b;
            data_a_d = rd_a;
            data_b_d = rd_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= (i == int'(IDX_SP)) ? SP_INIT : '0;
            end
            idx_a_q  <= IDX_EMPTY;
            idx_b_q  <= IDX_EMPTY;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            mem_q    <= mem_d;
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign bus.idx_a  = idx_a_q;
    assign bus.idx_b  = idx_b_q;
    assign bus.data_a = data_a_q;
    assign bus.data_b = data_b_q;

endmodule

// File: tb/tb_reg_read_file.sv
// Table-driven bench for reg_read_file with a scoreboard queue of expected ID/EX outputs.
module tb_reg_read_file;

    localparam logic [15:0] SP_VAL = 16'h5A00;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_idx;
        logic [15:0] wr_data;
        logic [7:0]  sel_a;
        logic [7:0]  sel_b;
        logic [3:0]  rx;
        logic [3:0]  ry;
        logic [3:0]  rz;
        logic        stall;
        logic        flush;
        logic [3:0]  e_idx_a;
        logic [3:0]  e_idx_b;
        logic [15:0] e_data_a;
        logic [15:0] e_data_b;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  idx_a;
        logic [3:0]  idx_b;
        logic [15:0] data_a;
        logic [15:0] data_b;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t tbl[11];

    reg_read_file_if #(.DATA_W(16)) bus ();

    reg_read_file #(.DATA_W(16), .SP_INIT(SP_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [3:0] wi, input logic [15:0] wd,
                                input logic [7:0] sa, input logic [7:0] sb,
                                input logic [3:0] rx, input logic [3:0] ry, input logic [3:0] rz,
                                input logic st, input logic fl,
                                input logic [3:0] ia, input logic [3:0] ib,
                                input logic [15:0] da, input logic [15:0] db);
        vec_t v;
        v.wr_en = we; v.wr_idx = wi; v.wr_data = wd;
        v.sel_a = sa; v.sel_b = sb;
        v.rx = rx; v.ry = ry; v.rz = rz;
        v.stall = st; v.flush = fl;
        v.e_idx_a = ia; v.e_idx_b = ib; v.e_data_a = da; v.e_data_b = db;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [3:0] ia, input logic [3:0] ib,
                                 input logic [15:0] da, input logic [15:0] db);
        check({name, ".idx_a"},  {12'h000, bus.idx_a}, {12'h000, ia});
        check({name, ".idx_b"},  {12'h000, bus.idx_b}, {12'h000, ib});
        check({name, ".data_a"}, bus.data_a, da);
        check({name, ".data_b"}, bus.data_b, db);
    endtask

    task automatic drive_idle();
        bus.wr_en = 1'b0; bus.wr_idx = 4'h0; bus.wr_data = 16'h0000;
        bus.rd_sel_a = 8'h0B; bus.rd_sel_b = 8'h0B;
        bus.regx = 4'h0; bus.regy = 4'h0; bus.regz = 4'h0;
        bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic step(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.wr_en = v.wr_en; bus.wr_idx = v.wr_idx; bus.wr_data = v.wr_data;
        bus.rd_sel_a = v.sel_a; bus.rd_sel_b = v.sel_b;
        bus.regx = v.rx; bus.regy = v.ry; bus.regz = v.rz;
        bus.stall = v.stall; bus.flush = v.flush;
        sb_q.push_back('{name, v.e_idx_a, v.e_idx_b, v.e_data_a, v.e_data_b});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            check_outputs(e.name, e.idx_a, e.idx_b, e.data_a, e.data_b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive_idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset", 4'hF, 4'hF, 16'h0000, 16'h0000);
        rst = 1'b1;

        //           we  wi    wd        sa     sb     rx    ry    rz    st fl   ia    ib    da        db
        tbl[0]  = mk(0, 4'h0, 16'h0000, 8'h09, 8'h0B, 4'h0, 4'h0, 4'h0, 0, 0, 4'hA, 4'hF, SP_VAL,   16'h0000);
        tbl[1]  = mk(1, 4'h3, 16'h1234, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF, 4'hF, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 4'h0, 16'h0000, 8'h06, 8'h08, 4'h0, 4'h3, 4'h0, 0, 0, 4'h3, 4'h9, 16'h1234, 16'h0000);
        tbl[3]  = mk(1, 4'h5, 16'hBEEF, 8'h05, 8'h29, 4'hA, 4'h0, 4'h0, 0, 0, 4'hA, 4'h5, SP_VAL,   16'hBEEF);
        tbl[4]  = mk(1, 4'hF, 16'h5555, 8'h0B, 8'h29, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF, 4'h5, 16'h0000, 16'hBEEF);
        tbl[5]  = mk(0, 4'h0, 16'h0000, 8'h07, 8'h0A, 4'h0, 4'h0, 4'hC, 0, 0, 4'hC, 4'hB, 16'h0000, 16'h0000);
        tbl[6]  = mk(1, 4'hC, 16'h7777, 8'h07, 8'h07, 4'h0, 4'h0, 4'hC, 0, 0, 4'hC, 4'hC, 16'h7777, 16'h7777);
        tbl[7]  = mk(1, 4'hB, 16'h00B0, 8'h0A, 8'hFF, 4'h0, 4'h0, 4'h0, 0, 0, 4'hB, 4'hF, 16'h00B0, 16'h0000);
        tbl[8]  = mk(0, 4'h0, 16'h0000, 8'h0A, 8'h0C, 4'h0, 4'h0, 4'h0, 0, 0, 4'hB, 4'hF, 16'h00B0, 16'h0000);
        tbl[9]  = mk(1, 4'h9, 16'h0999, 8'h08, 8'h05, 4'h9, 4'h0, 4'h0, 0, 0, 4'h9, 4'h9, 16'h0999, 16'h0999);
        tbl[10] = mk(0, 4'h0, 16'h0000, 8'h09, 8'h09, 4'h0, 4'h0, 4'h0, 0, 1, 4'hF, 4'hF, 16'h0000, 16'h0000);

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Multi-cycle stall with write-back refresh of the held operand.
        step("ld_r2",     mk(1, 4'h2, 16'h0001, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF, 4'hF, 16'h0000, 16'h0000));
        step("sel_r2",    mk(0, 4'h0, 16'h0000, 8'h05, 8'h29, 4'h2, 4'h0, 4'h0, 0, 0, 4'h2, 4'h5, 16'h0001, 16'hBEEF));
        step("stall1",    mk(0, 4'h0, 16'h0000, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 1, 0, 4'h2, 4'h5, 16'h0001, 16'hBEEF));
        step("stall2_wr", mk(1, 4'h2, 16'h00AA, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 1, 0, 4'h2, 4'h5, 16'h00AA, 16'hBEEF));
        step("stall3_wr7",mk(1, 4'h7, 16'h0777, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 1, 0, 4'h2, 4'h5, 16'h00AA, 16'hBEEF));
        step("rd_r7",     mk(0, 4'h0, 16'h0000, 8'h05, 8'h05, 4'h7, 4'h0, 4'h0, 0, 0, 4'h7, 4'h7, 16'h0777, 16'h0777));

        // Flush beats stall, while the write in the same cycle still lands.
        step("stall_flush", mk(1, 4'h6, 16'h6666, 8'h05, 8'h05, 4'h7, 4'h0, 4'h0, 1, 1, 4'hF, 4'hF, 16'h0000, 16'h0000));
        step("rd_r6",       mk(0, 4'h0, 16'h0000, 8'h05, 8'h06, 4'h6, 4'h2, 4'h0, 0, 0, 4'h6, 4'h2, 16'h6666, 16'h00AA));

        // Asynchronous reset in the middle of a stall.
        step("ld_sp",     mk(0, 4'h0, 16'h0000, 8'h09, 8'h29, 4'h0, 4'h0, 4'h0, 0, 0, 4'hA, 4'h5, SP_VAL,   16'hBEEF));
        step("stall_sp",  mk(1, 4'hA, 16'h1111, 8'h0B, 8'h0B, 4'h0, 4'h0, 4'h0, 1, 0, 4'hA, 4'h5, 16'h1111, 16'hBEEF));
        #2;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 4'hF, 4'hF, 16'h0000, 16'h0000);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst",  mk(0, 4'h0, 16'h0000, 8'h09, 8'h29, 4'h0, 4'h0, 4'h0, 0, 0, 4'hA, 4'h5, SP_VAL,   16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
        $fatal(1);
    end

endmodule
